// File: rtl/arbiter_types.sv
// Shared types for the instruction/data cache arbiter: FSM states,
// requester identities and the default cache line width.
package arbiter_types;

    localparam int LINE_W_DEF = 256;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        RECOVER = 2'd3
    } arb_state_t;

    typedef enum logic {
        ICACHE = 1'b0,
        DCACHE = 1'b1
    } requester_t;

endpackage

// File: rtl/cache_arbiter.sv
// Arbitrates one physical memory port between the icache (read-only line
// fills) and the dcache (line fills and write-backs). One transaction is in
// flight at a time; ties alternate between the two caches. After each
// completion a single RECOVER cycle lets the finished requester drop its
// request before the next grant is considered.
module cache_arbiter
    import arbiter_types::*;
#(
    parameter int LINE_W = LINE_W_DEF,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_pmem_read,
    input  logic [ADDR_W-1:0] i_pmem_address,
    output logic [LINE_W-1:0] i_pmem_rdata,
    output logic              i_pmem_resp,
    input  logic              d_pmem_read,
    input  logic              d_pmem_write,
    input  logic [ADDR_W-1:0] d_pmem_address,
    input  logic [LINE_W-1:0] d_pmem_wdata,
    output logic [LINE_W-1:0] d_pmem_rdata,
    output logic              d_pmem_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    arb_state_t        state_q, state_d;
    requester_t        last_grant_q, last_grant_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic              write_q, write_d;

    logic i_req;
    logic d_req;
    logic grant_d;

    assign i_req = i_pmem_read;
    // A simultaneous read+write from the dcache counts as a write.
    assign d_req = d_pmem_read | d_pmem_write;
    // Dcache wins when it is alone, or on a tie when the icache had the last grant.
    assign grant_d = d_req && (!i_req || (last_grant_q == ICACHE));

    // Fill data is broadcast to both caches; only the resp qualifies it.
    assign i_pmem_rdata = pmem_rdata;
    assign d_pmem_rdata = pmem_rdata;

    // The memory request is driven straight from the latched transaction so
    // it cannot follow requester changes mid-service.
    assign pmem_address = addr_q;
    assign pmem_wdata   = wdata_q;

    // State and latched-transaction registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= ICACHE;
            addr_q       <= '0;
            wdata_q      <= '0;
            write_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            write_q      <= write_d;
        end
    end

    // Grant selection, memory strobes and per-requester completion.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        write_d      = write_q;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        i_pmem_resp  = 1'b0;
        d_pmem_resp  = 1'b0;

        case (state_q)
            IDLE: begin
                if (grant_d) begin
                    state_d      = SERVE_D;
                    last_grant_d = DCACHE;
                    addr_d       = d_pmem_address;
                    wdata_d      = d_pmem_wdata;
                    write_d      = d_pmem_write;
                end else if (i_req) begin
                    state_d      = SERVE_I;
                    last_grant_d = ICACHE;
                    addr_d       = i_pmem_address;
                    wdata_d      = '0;
                    write_d      = 1'b0;
                end
            end
            SERVE_I: begin
                pmem_read = 1'b1;
                if (pmem_resp) begin
                    i_pmem_resp = 1'b1;
                    state_d     = RECOVER;
                end
            end
            SERVE_D: begin
                pmem_read  = !write_q;
                pmem_write = write_q;
                if (pmem_resp) begin
                    d_pmem_resp = 1'b1;
                    state_d     = RECOVER;
                end
            end
            RECOVER: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    a_dcache_rw_exclusive: assert property (@(posedge clk) disable iff (rst)
        !(d_pmem_read && d_pmem_write))
        else $error("dcache read and write asserted together; handled as a write");

endmodule

// File: tb/tb_cache_arbiter.sv
// Randomized scoreboard bench for cache_arbiter with a transaction-level
// reference model and a behavioural memory.
module tb_cache_arbiter;
    import arbiter_types::*;

    localparam int LW = 256;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_pmem_read;
    logic [AW-1:0] i_pmem_address;
    logic [LW-1:0] i_pmem_rdata;
    logic          i_pmem_resp;
    logic          d_pmem_read;
    logic          d_pmem_write;
    logic [AW-1:0] d_pmem_address;
    logic [LW-1:0] d_pmem_wdata;
    logic [LW-1:0] d_pmem_rdata;
    logic          d_pmem_resp;
    logic          pmem_read;
    logic          pmem_write;
    logic [AW-1:0] pmem_address;
    logic [LW-1:0] pmem_wdata;
    logic [LW-1:0] pmem_rdata;
    logic          pmem_resp;

    cache_arbiter #(.LINE_W(LW), .ADDR_W(AW)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_pmem_read    (i_pmem_read),
        .i_pmem_address (i_pmem_address),
        .i_pmem_rdata   (i_pmem_rdata),
        .i_pmem_resp    (i_pmem_resp),
        .d_pmem_read    (d_pmem_read),
        .d_pmem_write   (d_pmem_write),
        .d_pmem_address (d_pmem_address),
        .d_pmem_wdata   (d_pmem_wdata),
        .d_pmem_rdata   (d_pmem_rdata),
        .d_pmem_resp    (d_pmem_resp),
        .pmem_read      (pmem_read),
        .pmem_write     (pmem_write),
        .pmem_address   (pmem_address),
        .pmem_wdata     (pmem_wdata),
        .pmem_rdata     (pmem_rdata),
        .pmem_resp      (pmem_resp)
    );

    always #5 clk = ~clk;

    typedef struct {
        requester_t    who;
        logic [AW-1:0] addr;
        logic          write;
        logic [LW-1:0] wdata;
    } txn_t;

    txn_t       exp_q[$];
    txn_t       cur;
    bit         m_busy = 1'b0;
    int         m_cool = 0;
    requester_t m_last = ICACHE;
    requester_t grant_log[$];
    int         checks = 0;
    int         errors = 0;
    bit         mem_auto = 1'b0;
    int         mem_cnt = 0;

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] v;
        for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [AW-1:0] rand_addr();
        logic [AW-1:0] a;
        a = $urandom;
        return a & ~32'h1F;
    endfunction

    task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: one transaction at a time, one dead cycle after each
    // completion, ties go to whoever was not granted last.
    initial begin
        bit iw, dw;
        txn_t t;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_busy = 1'b0;
                m_cool = 0;
                m_last = ICACHE;
                exp_q.delete();
            end else if (m_busy) begin
                if (pmem_resp) begin
                    m_busy = 1'b0;
                    m_cool = 1;
                end
            end else if (m_cool > 0) begin
                m_cool--;
            end else begin
                iw = i_pmem_read;
                dw = d_pmem_read || d_pmem_write;
                if (iw || dw) begin
                    if (iw && dw) t.who = (m_last == ICACHE) ? DCACHE : ICACHE;
                    else          t.who = dw ? DCACHE : ICACHE;
                    if (t.who == DCACHE) begin
                        t.addr  = d_pmem_address;
                        t.write = d_pmem_write;
                        t.wdata = d_pmem_wdata;
                    end else begin
                        t.addr  = i_pmem_address;
                        t.write = 1'b0;
                        t.wdata = '0;
                    end
                    m_last = t.who;
                    cur    = t;
                    m_busy = 1'b1;
                    exp_q.push_back(t);
                end
            end
        end
    end

    // Monitor: compares memory-side strobes every cycle and pops the
    // scoreboard whenever a cache sees a response.
    initial begin
        txn_t t;
        forever begin
            @(negedge clk);
            chk("i_rdata_pass", i_pmem_rdata, pmem_rdata);
            chk("d_rdata_pass", d_pmem_rdata, pmem_rdata);
            chk("strobe_excl", LW'(pmem_read && pmem_write), '0);
            if (m_busy) begin
                chk("pmem_read", LW'(pmem_read), LW'(!cur.write));
                chk("pmem_write", LW'(pmem_write), LW'(cur.write));
                chk("pmem_address", LW'(pmem_address), LW'(cur.addr));
                if (cur.write) chk("pmem_wdata", pmem_wdata, cur.wdata);
            end else begin
                chk("idle_strobes", LW'({pmem_read, pmem_write}), '0);
            end
            if (i_pmem_resp || d_pmem_resp) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_resp got i=%0b d=%0b expected none at %0t",
                             i_pmem_resp, d_pmem_resp, $time);
                end else begin
                    t = exp_q.pop_front();
                    chk("resp_i", LW'(i_pmem_resp), LW'(t.who == ICACHE));
                    chk("resp_d", LW'(d_pmem_resp), LW'(t.who == DCACHE));
                    chk("resp_with_pmem", LW'(pmem_resp), LW'(1));
                    grant_log.push_back(t.who);
                end
            end else if (m_busy && pmem_resp) begin
                checks++;
                errors++;
                $display("FAIL missing_resp got none expected %s at %0t",
                         (cur.who == DCACHE) ? "dcache" : "icache", $time);
            end
        end
    end

    // Memory: random latency per transaction, random fill data every cycle,
    // occasional stray resp pulses while nothing is being served.
    initial begin
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_auto) begin
                pmem_resp  = 1'b0;
                pmem_rdata = rand_line();
                if (mem_cnt > 0) begin
                    mem_cnt--;
                    if (mem_cnt == 0) pmem_resp = 1'b1;
                end else if (pmem_read || pmem_write) begin
                    mem_cnt = $urandom_range(1, 4);
                end else if ($urandom_range(0, 7) == 0) begin
                    pmem_resp = 1'b1;
                end
            end else begin
                mem_cnt = 0;
            end
        end
    end

    // One cache: n transactions, random idle gap, request held until resp
    // while its address/data wander (the arbiter must ignore the changes).
    task automatic run_req(input bit is_d, input int n, input int maxgap);
        bit done;
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, maxgap)) begin
                @(posedge clk);
                #1;
            end
            if (is_d) begin
                d_pmem_address = rand_addr();
                d_pmem_wdata   = rand_line();
                if ($urandom_range(0, 1) == 1) begin
                    d_pmem_write = 1'b1;
                    d_pmem_read  = 1'b0;
                end else begin
                    d_pmem_write = 1'b0;
                    d_pmem_read  = 1'b1;
                end
            end else begin
                i_pmem_address = rand_addr();
                i_pmem_read    = 1'b1;
            end
            done = 1'b0;
            for (int c = 0; c < 200; c++) begin
                @(negedge clk);
                if (is_d ? d_pmem_resp : i_pmem_resp) begin
                    done = 1'b1;
                    break;
                end
                @(posedge clk);
                #1;
                if ($urandom_range(0, 3) == 0) begin
                    if (is_d) begin
                        d_pmem_address = rand_addr();
                        d_pmem_wdata   = rand_line();
                    end else begin
                        i_pmem_address = rand_addr();
                    end
                end
            end
            if (!done) begin
                checks++;
                errors++;
                $display("FAIL req_timeout got no resp expected resp for %s", is_d ? "dcache" : "icache");
            end
            @(posedge clk);
            #1;
            if (is_d) begin
                d_pmem_read  = 1'b0;
                d_pmem_write = 1'b0;
            end else begin
                i_pmem_read = 1'b0;
            end
        end
    endtask

    initial begin
        requester_t alt[6];
        bit seen;
        alt = '{DCACHE, ICACHE, DCACHE, ICACHE, DCACHE, ICACHE};

        rst            = 1'b1;
        i_pmem_read    = 1'b0;
        i_pmem_address = '0;
        d_pmem_read    = 1'b0;
        d_pmem_write   = 1'b0;
        d_pmem_address = '0;
        d_pmem_wdata   = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_pmem_read", LW'(pmem_read), '0);
        chk("rst_pmem_write", LW'(pmem_write), '0);
        chk("rst_pmem_address", LW'(pmem_address), '0);
        chk("rst_pmem_wdata", pmem_wdata, '0);
        chk("rst_i_resp", LW'(i_pmem_resp), '0);
        chk("rst_d_resp", LW'(d_pmem_resp), '0);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        mem_auto = 1'b1;

        // Both caches request together from reset and keep requesting.
        fork
            run_req(1'b0, 3, 0);
            run_req(1'b1, 3, 0);
        join
        chk("tie_grant_count", LW'(grant_log.size()), LW'(6));
        for (int k = 0; k < 6; k++) begin
            if (k < grant_log.size()) chk($sformatf("tie_grant_%0d", k), LW'(grant_log[k]), LW'(alt[k]));
        end
        grant_log.delete();

        // Randomized traffic with gaps.
        fork
            run_req(1'b0, 25, 3);
            run_req(1'b1, 25, 3);
        join
        chk("rand_grant_count", LW'(grant_log.size()), LW'(50));

        // Reset in the middle of a dcache fill, followed by a late resp.
        mem_auto = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        pmem_resp      = 1'b0;
        d_pmem_address = 32'h0000_2040;
        d_pmem_read    = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (pmem_read) begin
                seen = 1'b1;
                break;
            end
        end
        chk("rst_test_read_seen", LW'(seen), LW'(1));
        chk("rst_test_addr", LW'(pmem_address), LW'(32'h0000_2040));
        @(posedge clk);
        @(posedge clk);
        #1;
        rst         = 1'b1;
        d_pmem_read = 1'b0;
        #1;
        chk("midrst_pmem_read", LW'(pmem_read), '0);
        chk("midrst_pmem_write", LW'(pmem_write), '0);
        chk("midrst_pmem_address", LW'(pmem_address), '0);
        chk("midrst_pmem_wdata", pmem_wdata, '0);
        chk("midrst_d_resp", LW'(d_pmem_resp), '0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        pmem_resp = 1'b1;
        @(negedge clk);
        chk("late_resp_d", LW'(d_pmem_resp), '0);
        chk("late_resp_i", LW'(i_pmem_resp), '0);
        @(posedge clk);
        #1;
        pmem_resp = 1'b0;
        repeat (2) @(negedge clk);
        chk("post_rst_idle", LW'({pmem_read, pmem_write}), '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute bound on run time.
    initial begin
        #200000;
        $display("FAIL global_timeout got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
